// File: rtl/mul_div_unit_pkg.sv
// Shared encodings and sizes for the iterative MIPS multiply/divide unit.
package mul_div_unit_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CALC = 2'b01,
      S_FIX  = 2'b10
   } state_e;

   function automatic logic op_is_signed(input op_e o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

   function automatic logic op_is_div(input op_e o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit_adder32.sv
// 32-bit carry-out adder, the same structure the ALU adder uses.
module mul_div_unit_adder32
   import mul_div_unit_pkg::*;
(
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            cin_i,
   output logic [XLEN-1:0] sum_o,
   output logic            cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{XLEN{1'b0}}, cin_i};

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU with HI/LO: sign-magnitude operands, one
// shift-add (multiply) or restoring-subtract (divide) step per cycle through one adder.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = XLEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               is_div_q, is_div_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic               b_zero_q, b_zero_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic [WIDTH-1:0]   ph_q, ph_d;   // product high half / partial remainder
   logic [WIDTH-1:0]   pl_q, pl_d;   // product low half / quotient
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   op_e                op_in;
   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   r_shift;
   logic [WIDTH-1:0]   add_a, add_b, add_sum;
   logic               add_cin, add_cout;
   logic               div_ok;
   logic [2*WIDTH-1:0] prod;

   assign op_in   = op_e'(op);
   assign sign_a  = op_is_signed(op_in) & A[WIDTH-1];
   assign sign_b  = op_is_signed(op_in) & B[WIDTH-1];
   assign r_shift = {ph_q[WIDTH-2:0], pl_q[WIDTH-1]};

   always_comb begin
      if (is_div_q) begin
         add_a   = r_shift;
         add_b   = ~mag_b_q;
         add_cin = 1'b1;
      end else begin
         add_a   = ph_q;
         add_b   = pl_q[0] ? mag_a_q : '0;
         add_cin = 1'b0;
      end
   end

   mul_div_unit_adder32 u_adder32 (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // NOTE: every next-state signal gets its hold value first, so no path through
   // the case below can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      b_zero_d  = b_zero_q;
      mag_a_d   = mag_a_q;
      mag_b_d   = mag_b_q;
      ph_d      = ph_q;
      pl_d      = pl_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      div_ok    = 1'b0;
      prod      = {ph_q, pl_q};

      case (state_q)
         S_IDLE: begin
            if (start) begin
               is_div_d  = op_is_div(op_in);
               neg_res_d = sign_a ^ sign_b;
               neg_rem_d = sign_a;
               b_zero_d  = (B == '0);
               mag_a_d   = sign_a ? -A : A;
               mag_b_d   = sign_b ? -B : B;
               ph_d      = '0;
               pl_d      = op_is_div(op_in) ? (sign_a ? -A : A) : (sign_b ? -B : B);
               cnt_d     = '0;
               state_d   = S_CALC;
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end

         S_CALC: begin
            if (is_div_q) begin
               // A set remainder MSB means the shifted value exceeds any divisor.
               div_ok = add_cout | ph_q[WIDTH-1];
               ph_d   = div_ok ? add_sum : r_shift;
               pl_d   = {pl_q[WIDTH-2:0], div_ok};
            end else begin
               ph_d = {add_cout, add_sum[WIDTH-1:1]};
               pl_d = {add_sum[0], pl_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end

         S_FIX: begin
            if (is_div_q) begin
               lo_d = b_zero_q ? '1 : (neg_res_q ? -pl_q : pl_q);
               hi_d = neg_rem_q ? -ph_q : ph_q;
            end else begin
               if (neg_res_q) prod = -{ph_q, pl_q};
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         b_zero_q  <= 1'b0;
         mag_a_q   <= '0;
         mag_b_q   <= '0;
         ph_q      <= '0;
         pl_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         b_zero_q  <= b_zero_d;
         mag_a_q   <= mag_a_d;
         mag_b_q   <= mag_b_d;
         ph_q      <= ph_d;
         pl_q      <= pl_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected {hi,lo} queued at launch, checked on done.
module tb_mul_div_unit;
   import mul_div_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] A, B, wdata;
   logic        mthi, mtlo;
   logic        busy, done;
   logic [31:0] hi, lo;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [63:0] sb_q[$];
   logic [63:0] exp_v;

   always #5 clk = ~clk;

   mul_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .wdata (wdata),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Reference model: returns {hi, lo}.
   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sbv, q, r;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      case (o)
         2'b00: begin p = 64'(sa * sbv); return p; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; return p; end
         2'b10: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            q = sa / sbv;
            r = sa % sbv;
            return {r[31:0], q[31:0]};
         end
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Result monitor: every done pulse must match the oldest outstanding op.
   always @(negedge clk) begin
      if (!reset && done) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: done=1 hi=%h lo=%h, expected no result", hi, lo);
         end else begin
            exp_v = sb_q.pop_front();
            if ({hi, lo} !== exp_v) begin
               n_fail++;
               $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                        hi, lo, exp_v[63:32], exp_v[31:0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a negedge with the unit idle; returns at the negedge after E0.
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] expv);
      op    = o;
      A     = a;
      B     = b;
      start = 1'b1;
      sb_q.push_back(expv);
      @(negedge clk);
      start = 1'b0;
      op    = 2'($urandom);
      A     = $urandom;
      B     = $urandom;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_timeout: done=0 after 60 cycles, expected done=1", tag);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0; op = 2'b00; A = '0; B = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_checks++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
      n_checks++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_multu_timing();
      int lat = -1;
      int busy_cycles = 0;
      start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
      if (busy) busy_cycles++;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 16) begin
            n_checks++;
            if ({hi, lo} !== 64'd0) begin
               n_fail++;
               $display("FAIL hold_during_calc: got hi=%h lo=%h expected both 0", hi, lo);
            end
         end
         if (done) begin lat = k; break; end
         if (busy) busy_cycles++;
      end
      n_checks++;
      if (lat != 33) begin n_fail++; $display("FAIL done_latency: done after edge E%0d, expected E33", lat); end
      n_checks++;
      if (busy_cycles != 33) begin n_fail++; $display("FAIL busy_cycles: got %0d expected 33", busy_cycles); end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL done_pulse: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_signed();
      start_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      wait_done("mult");
      start_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_done("div");
      start_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
      wait_done("divu");
   endtask

   task automatic test_corner();
      start_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
      wait_done("div_overflow");
      start_op(OP_DIVU, 32'd5, 32'd0, {32'h0000_0005, 32'hFFFF_FFFF});
      wait_done("divu_by_zero");
      start_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      wait_done("div_by_zero");
   endtask

   task automatic test_mid_op();
      logic [31:0] hi_before;
      hi_before = hi;
      start_op(OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      repeat (9) @(negedge clk);
      start = 1'b1; op = OP_MULTU; A = 32'd3; B = 32'd4;
      mthi = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; mthi = 1'b0;
      n_checks++;
      if (hi !== hi_before) begin
         n_fail++;
         $display("FAIL mthi_while_busy: got hi=%h expected %h", hi, hi_before);
      end
      wait_done("mid_op");
      repeat (45) @(negedge clk);
   endtask

   task automatic test_mid_reset();
      start_op(OP_MULTU, 32'h1234_5678, 32'h0000_0100, model(OP_MULTU, 32'h1234_5678, 32'h0000_0100));
      repeat (19) @(negedge clk);
      #2 reset = 1'b1;
      sb_q.delete();
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
         n_fail++;
         $display("FAIL after_reset_idle: got busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      mthi = 1'b0; mtlo = 1'b0;
      n_checks++;
      if ({hi, lo} !== {32'h1234_5678, 32'h1234_5678}) begin
         n_fail++;
         $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected 12345678 12345678", hi, lo);
      end
      mtlo = 1'b1; wdata = 32'h9ABC_DEF0;
      @(negedge clk);
      mtlo = 1'b0;
      n_checks++;
      if ({hi, lo} !== {32'h1234_5678, 32'h9ABC_DEF0}) begin
         n_fail++;
         $display("FAIL mtlo_only: got hi=%h lo=%h expected 12345678 9abcdef0", hi, lo);
      end
   endtask

   task automatic test_start_with_mtlo();
      mtlo = 1'b1; wdata = 32'h5555_5555;
      start_op(OP_MULTU, 32'd2, 32'd3, {32'd0, 32'd6});
      mtlo = 1'b0;
      n_checks++;
      if (lo !== 32'h9ABC_DEF0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_beats_mtlo: got lo=%h busy=%b expected 9abcdef0 1", lo, busy);
      end
      wait_done("start_mtlo");
   endtask

   task automatic test_back_to_back();
      logic [1:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         o = 2'(i);
         a = $urandom;
         b = (i == 6) ? 32'd0 : ((i == 3) ? 32'h8000_0001 : $urandom);
         if (i == 7) a = 32'd13;
         start_op(o, a, b, model(o, a, b));
         wait_done("back_to_back");
      end
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_multu_timing();
      test_signed();
      test_corner();
      test_mid_op();
      test_mid_reset();
      test_mthi_mtlo();
      test_start_with_mtlo();
      test_back_to_back();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL outstanding: %0d results never produced, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
